alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Parametrised, handshaked ALU for the single-cycle CPU datapath and its planned multi-cycle successor. It extends the existing four-operation 16-bit ALU to a WIDTH-bit unit with logic, arithmetic-shift, iterative multiply and unsigned divide. It also adds registered results with carry/overflow/negative/divide-by-zero flags and valid/ready flow control. It sits between the register-file read stage and writeback; the control unit drives opcodes and stalls on `in_ready`/`out_valid`.

## Interface
- WIDTH, 16, operand/result width; power of two, ≥4. Localparam SHW = $clog2(WIDTH).
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  unit can accept this cycle
- ALU_InA  in  WIDTH  operand A (shift amount for shifts = ALU_InA[SHW-1:0])
- ALU_InB  in  WIDTH  operand B
- ALU_cont  in  4  opcode
- out_valid  out  1  result/flags valid, held until consumed
- out_ready  in  1  consumer accepts result
- ALU_output  out  WIDTH  primary result
- ALU_output_hi  out  WIDTH  MUL high half / DIVU remainder, else 0
- ALU_zero, ALU_carry, ALU_ovf, ALU_neg, ALU_dz  out  1 each  flags

## Operation
- Opcodes: 0000 ADD, 0001 SUB (A−B), 0010 SLL (B<<A), 0011 AND, 0100 OR, 0101 XOR, 0110 SRL (B>>A, logical), 0111 SRA (B>>>A), 1000 MUL (unsigned, 2·WIDTH product), 1001 DIVU (A/B). Others: result 0, single-cycle.
- FSM states IDLE, BUSY, DONE. Reset → IDLE; all outputs 0, except in_ready=1.
- in_ready = (IDLE) or (DONE and out_ready). Accept = in_valid & in_ready.
- Accept of a single-cycle opcode: result and flags registered, next state DONE.
- Accept of MUL/DIVU: operands latched, counter=WIDTH, next state BUSY. One shift-add or restoring-subtract iteration per cycle; counter reaching 0 → DONE with result registered.
- DONE: out_valid=1; outputs stable while out_ready=0. out_ready=1 → IDLE, or direct reload if a new accept occurs in the same cycle.
- Flags: ALU_zero = (ALU_output==0) for every opcode. ALU_neg = ALU_output[WIDTH-1]. ALU_carry = carry-out (ADD) or no-borrow, i.e. A≥B unsigned (SUB), else 0. ALU_ovf = signed overflow (ADD/SUB), else 0. ALU_dz = 1 only for DIVU with B=0.
- DIVU with B=0: quotient all-ones, remainder = A, still takes the full iteration latency.
- in_valid while BUSY: ignored (in_ready=0); inputs are not sampled.

## Timing
- Single-cycle ops: accept at edge N, out_valid high after edge N+1 (latency 1).
- MUL/DIVU: out_valid high after edge N+1+WIDTH (17 cycles for WIDTH=16).
- Throughput with out_ready held high: one single-cycle op per cycle via DONE→DONE reload.
- out_valid drops the cycle after consumption unless reloaded.
- rst_n assertion at any time (including mid-BUSY): immediate return to IDLE, outputs cleared, in-flight op discarded. Release is synchronised to clk by the top level.

## Structure
- Shared package alu_pkg: opcode localparams (ALU_ADD … ALU_DIVU), FSM state encoding, flag bit-index constants.
- One sub-module: alu_muldiv_iter (WIDTH-parametrised iterative engine: start, op select, done, product/quotient/remainder). Combinational ops stay in alu_seq_unit.

## Test plan
- ADD 0x7FFF+0x0001 → 0x8000, ovf=1, neg=1, carry=0, zero=0, out_valid one cycle after accept.
- SUB 0x0005−0x0005 → 0x0000, zero=1, carry=1. SLL A=0x0004, B=0x0003 → 0x0030. SRA A=1, B=0x8000 → 0xC000.
- MUL 0x1234×0x0100 → ALU_output 0x3400, ALU_output_hi 0x0012, out_valid 17 cycles after accept, in_ready=0 throughout BUSY.
- DIVU 0x0064/0x0007 → 0x000E r 0x0002. DIVU 0x0055/0 → 0xFFFF, hi 0x0055, dz=1.
- Backpressure: out_ready low for 5 cycles in DONE → outputs and flags unchanged, in_ready=0; then back-to-back ADDs with out_ready=1 → one result per cycle.
- rst_n pulsed low at cycle 8 of a MUL → all outputs 0 and in_ready=1 immediately; next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag bit positions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_NEG   = 3;
    localparam int unsigned FLAG_DZ    = 4;
    localparam int unsigned NUM_FLAGS  = 5;

    // MUL and DIVU go through the iterative engine; everything else is one cycle.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    // hi holds the partial product high half / running remainder,
    // lo holds the multiplier being shifted out / quotient being shifted in.
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;

    // The step in flight this cycle is the final one; its results are lo_nxt/hi_nxt.
    assign last = (cnt_q == CW'(1));

    // One iteration of whichever algorithm is running.
    always_comb begin
        add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        shifted = {hi_q, lo_q[WIDTH-1]};
        lo_nxt  = lo_q;
        hi_nxt  = hi_q;
        if (div_q) begin
            // A zero divisor never borrows, giving all-ones quotient and remainder = A.
            if (shifted >= {1'b0, opnd_q}) begin
                hi_nxt = WIDTH'(shifted - {1'b0, opnd_q});
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = add_sum[WIDTH:1];
            lo_nxt = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Load operands on start, then iterate until the counter runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= op_div ? a : b;
            opnd_q <= op_div ? b : a;
            cnt_q  <= CW'(WIDTH);
            div_q  <= op_div;
        end else if (cnt_q != '0) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALU_InA,
    input  logic [WIDTH-1:0] ALU_InB,
    input  logic [3:0]       ALU_cont,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_output,
    output logic [WIDTH-1:0] ALU_output_hi,
    output logic             ALU_zero,
    output logic             ALU_carry,
    output logic             ALU_ovf,
    output logic             ALU_neg,
    output logic             ALU_dz
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e             state_q, state_d;
    logic [WIDTH-1:0]       res_q, hi_q;
    logic [NUM_FLAGS-1:0]   flags_q, flags_c, flags_it;
    logic                   dz_q;
    logic                   accept, start, load_single, load_iter;
    logic [WIDTH-1:0]       res_c;
    logic [WIDTH:0]         sum, diff;
    logic [SHW-1:0]         shamt;
    logic                   it_last;
    logic [WIDTH-1:0]       it_lo, it_hi;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_div (ALU_cont == ALU_DIVU),
        .a      (ALU_InA),
        .b      (ALU_InB),
        .last   (it_last),
        .lo_nxt (it_lo),
        .hi_nxt (it_hi)
    );

    // Single-cycle datapath and its flags.
    always_comb begin
        sum     = {1'b0, ALU_InA} + {1'b0, ALU_InB};
        diff    = {1'b0, ALU_InA} - {1'b0, ALU_InB};
        shamt   = ALU_InA[SHW-1:0];
        res_c   = '0;
        flags_c = '0;
        case (ALU_cont)
            ALU_ADD: begin
                res_c                = sum[WIDTH-1:0];
                flags_c[FLAG_CARRY]  = sum[WIDTH];
                flags_c[FLAG_OVF]    = (ALU_InA[WIDTH-1] == ALU_InB[WIDTH-1]) &&
                                       (sum[WIDTH-1] != ALU_InA[WIDTH-1]);
            end
            ALU_SUB: begin
                res_c                = diff[WIDTH-1:0];
                flags_c[FLAG_CARRY]  = ~diff[WIDTH];
                flags_c[FLAG_OVF]    = (ALU_InA[WIDTH-1] != ALU_InB[WIDTH-1]) &&
                                       (diff[WIDTH-1] != ALU_InA[WIDTH-1]);
            end
            ALU_SLL: res_c = ALU_InB << shamt;
            ALU_AND: res_c = ALU_InA & ALU_InB;
            ALU_OR:  res_c = ALU_InA | ALU_InB;
            ALU_XOR: res_c = ALU_InA ^ ALU_InB;
            ALU_SRL: res_c = ALU_InB >> shamt;
            ALU_SRA: res_c = $signed(ALU_InB) >>> shamt;
            default: res_c = '0;
        endcase
        flags_c[FLAG_ZERO] = (res_c == '0);
        flags_c[FLAG_NEG]  = res_c[WIDTH-1];
    end

    // Flags for an iterative result, formed from the engine's final step.
    always_comb begin
        flags_it            = '0;
        flags_it[FLAG_ZERO] = (it_lo == '0);
        flags_it[FLAG_NEG]  = it_lo[WIDTH-1];
        flags_it[FLAG_DZ]   = dz_q;
    end

    // FSM next state and load strobes; an accept in DONE reloads directly.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        load_single = 1'b0;
        load_iter   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (is_iterative(ALU_cont)) begin
                        start   = 1'b1;
                        state_d = StBusy;
                    end else begin
                        load_single = 1'b1;
                        state_d     = StDone;
                    end
                end else if (state_q == StDone && out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (it_last) begin
                    load_iter = 1'b1;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, result and flag registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                dz_q <= (ALU_cont == ALU_DIVU) && (ALU_InB == '0);
            end
            if (load_single) begin
                res_q   <= res_c;
                hi_q    <= '0;
                flags_q <= flags_c;
            end else if (load_iter) begin
                res_q   <= it_lo;
                hi_q    <= it_hi;
                flags_q <= flags_it;
            end
        end
    end

    assign ALU_output    = res_q;
    assign ALU_output_hi = hi_q;
    assign ALU_zero      = flags_q[FLAG_ZERO];
    assign ALU_carry     = flags_q[FLAG_CARRY];
    assign ALU_ovf       = flags_q[FLAG_OVF];
    assign ALU_neg       = flags_q[FLAG_NEG];
    assign ALU_dz        = flags_q[FLAG_DZ];

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed plus randomized bench for alu_seq_unit against an arithmetic reference model.
module tb_alu_seq_unit;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res, res_hi;
    logic         f_zero, f_carry, f_ovf, f_neg, f_dz;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [4:0]   flags; // {zero, carry, ovf, neg, dz}
    } exp_t;

    alu_seq_unit #(
        .WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ALU_InA       (a),
        .ALU_InB       (b),
        .ALU_cont      (op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_output    (res),
        .ALU_output_hi (res_hi),
        .ALU_zero      (f_zero),
        .ALU_carry     (f_carry),
        .ALU_ovf       (f_ovf),
        .ALU_neg       (f_neg),
        .ALU_dz        (f_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] dut_flags();
        return {f_zero, f_carry, f_ovf, f_neg, f_dz};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode's definition.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t   e;
        longint m    = longint'(1) << W;
        longint half = m / 2;
        longint ux   = longint'(x);
        longint uy   = longint'(y);
        longint sx   = x[W-1] ? ux - m : ux;
        longint sy   = y[W-1] ? uy - m : uy;
        longint r;
        int     sh   = int'(ux % W);
        logic   zero, carry, ovf, neg, dz;
        e.lo = '0; e.hi = '0;
        carry = 1'b0; ovf = 1'b0; dz = 1'b0;
        case (o)
            4'd0: begin
                r = ux + uy; e.lo = W'(r); carry = (r >= m);
                r = sx + sy; ovf = (r > half - 1) || (r < -half);
            end
            4'd1: begin
                r = ux - uy; e.lo = W'(r); carry = (ux >= uy);
                r = sx - sy; ovf = (r > half - 1) || (r < -half);
            end
            4'd2: begin r = uy << sh;  e.lo = W'(r); end
            4'd3: e.lo = x & y;
            4'd4: e.lo = x | y;
            4'd5: e.lo = x ^ y;
            4'd6: begin r = uy >> sh;  e.lo = W'(r); end
            4'd7: begin r = sy >>> sh; e.lo = W'(r); end
            4'd8: begin r = ux * uy; e.lo = W'(r); e.hi = W'(r >> W); end
            4'd9: begin
                if (uy == 0) begin
                    e.lo = W'(m - 1); e.hi = x; dz = 1'b1;
                end else begin
                    e.lo = W'(ux / uy); e.hi = W'(ux % uy);
                end
            end
            default: e.lo = '0;
        endcase
        zero = (e.lo == 0);
        neg  = e.lo[W-1];
        e.flags = {zero, carry, ovf, neg, dz};
        return e;
    endfunction

    // Present one op from IDLE, drive junk while it is in flight, check latency and result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit consume);
        exp_t e = model(o, x, y);
        int   lat = 0;
        int   exp_lat = (o == 4'd8 || o == 4'd9) ? W + 1 : 1;
        bit   busy_bad = 0;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom);
            if (!out_valid && in_ready) busy_bad = 1;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_not_ready"}, 32'(busy_bad), 32'd0);
        check({tag, "_result"}, 32'(res), 32'(e.lo));
        check({tag, "_result_hi"}, 32'(res_hi), 32'(e.hi));
        check({tag, "_flags"}, 32'(dut_flags()), 32'(e.flags));
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] held_res, held_hi;
        logic [4:0]   held_flags;
        exp_t         e;
        logic [W-1:0] ra, rb;
        logic [W-1:0] corners [6];
        corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'h0001; corners[5] = 16'h000F;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #1 rst_n = 1'b0;
        #20;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", {res, res_hi}, 32'd0);
        check("reset_flags", 32'(dut_flags()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_op("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 1);
        run_op("sub_zero", 4'd1, 16'h0005, 16'h0005, 1);
        run_op("sll",      4'd2, 16'h0004, 16'h0003, 1);
        run_op("sra",      4'd7, 16'h0001, 16'h8000, 1);
        run_op("mul",      4'd8, 16'h1234, 16'h0100, 1);
        run_op("divu",     4'd9, 16'h0064, 16'h0007, 1);
        run_op("divu_dz",  4'd9, 16'h0055, 16'h0000, 1);
        run_op("bad_op",   4'd13, 16'h1234, 16'h5678, 1);

        // Backpressure: hold the result for five cycles.
        run_op("bp_add", 4'd0, 16'h1111, 16'h2222, 0);
        held_res = res; held_hi = res_hi; held_flags = dut_flags();
        in_valid = 1'b1; op = 4'd0; a = 16'h0F0F; b = 16'h0101;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_stable", {res, res_hi}, {held_res, held_hi});
            check("bp_flags", 32'(dut_flags()), 32'(held_flags));
        end

        // Back-to-back ADDs, one result per cycle via DONE reload.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            e = model(4'd0, ra, rb);
            op = 4'd0; a = ra; b = rb; in_valid = 1'b1;
            @(posedge clk); #1;
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_result", 32'(res), 32'(e.lo));
            check("b2b_flags", 32'(dut_flags()), 32'(e.flags));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drain", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of a MUL.
        op = 4'd8; a = 16'hABCD; b = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mul_mid_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_outputs", {res, res_hi}, 32'd0);
        check("rst_mid_flags", 32'(dut_flags()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_add", 4'd0, 16'h0100, 16'h0023, 1);

        // Randomized ops with occasional corner operands.
        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            run_op("rand", 4'($urandom_range(0, 15)), ra, rb, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
